// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: byte transaction queue in front of spi_master.
// Host bytes (with a chip-select code) are buffered in a TX FIFO. Each byte
// becomes one spi_master frame, launched with a single-cycle M_TX_EN pulse.
// The byte received on M_TC is written to an RX FIFO that the host drains.
// A minimum inter-frame gap, a completion timeout and sticky error flags
// wrap the sequencing.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a queued byte and spi_master not busy
// LAUNCH   | M_TX_EN high for this one cycle, timeout timer loaded
// WAIT_TC  | waiting for M_TC, timer counting down to abort
// GAP      | enforced quiet time before the next launch
module spi_xfer_queue #(
   parameter int DEPTH          = 8,
   parameter int AW             = 3,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          CLK,
   input  logic          RST_,
   input  logic          PUSH,
   input  logic [7:0]    PUSH_DATA,
   input  logic [1:0]    PUSH_CS,
   output logic          TX_FULL,
   output logic [AW:0]   TX_LEVEL,
   input  logic          POP,
   output logic [7:0]    POP_DATA,
   output logic          RX_EMPTY,
   output logic          M_TX_EN,
   output logic [7:0]    M_TX_DATA,
   output logic [1:0]    M_CSI,
   input  logic          M_BUSY,
   input  logic          M_TC,
   input  logic [7:0]    M_RX_DATA,
   output logic          ACTIVE,
   output logic [2:0]    ERR,
   input  logic          CLR_ERR
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LAUNCH  = 2'd1;
   localparam logic [1:0] ST_WAIT_TC = 2'd2;
   localparam logic [1:0] ST_GAP     = 2'd3;

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

   logic [1:0]    state;

   // TX FIFO storage and bookkeeping
   logic [9:0]    tx_mem [DEPTH];
   logic [AW-1:0] tx_wr_ptr;
   logic [AW-1:0] tx_rd_ptr;
   logic [AW:0]   tx_level;
   logic          tx_full;
   logic          tx_empty;
   logic          tx_pop;
   logic          tx_push_ok;
   logic          tx_ovf;

   // RX FIFO storage and bookkeeping
   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] rx_wr_ptr;
   logic [AW-1:0] rx_rd_ptr;
   logic [AW:0]   rx_level;
   logic          rx_full;
   logic          rx_empty;
   logic          rx_tc;
   logic          rx_wr;
   logic          rx_rd;
   logic          rx_ovf;

   logic [15:0]   tmo_cnt;
   logic [15:0]   gap_cnt;
   logic          tmo_expire;

   logic          m_tx_en;
   logic [7:0]    m_tx_data;
   logic [1:0]    m_csi;
   logic [2:0]    err;
   logic [2:0]    err_set;

   assign tx_full  = (tx_level == FULL_LVL);
   assign tx_empty = (tx_level == '0);
   assign rx_full  = (rx_level == FULL_LVL);
   assign rx_empty = (rx_level == '0);

   // A launch consumes the TX head; a push that coincides with it is accepted
   // even at full because a slot frees up in the same cycle.
   assign tx_pop     = (state == ST_IDLE) && !tx_empty && !M_BUSY;
   assign tx_push_ok = PUSH && (!tx_full || tx_pop);
   assign tx_ovf     = PUSH && tx_full && !tx_pop;

   // Same reasoning for RX: a host pop at full makes room for the new byte.
   assign rx_tc  = (state == ST_WAIT_TC) && M_TC;
   assign rx_wr  = rx_tc && (!rx_full || POP);
   assign rx_ovf = rx_tc && rx_full && !POP;
   assign rx_rd  = POP && !rx_empty;

   assign tmo_expire = (state == ST_WAIT_TC) && !M_TC && (tmo_cnt == '0);
   assign err_set    = {tmo_expire, rx_ovf, tx_ovf};

   // TX FIFO data array
   always_ff @(posedge CLK) begin
      if (tx_push_ok) begin
         tx_mem[tx_wr_ptr] <= {PUSH_CS, PUSH_DATA};
      end
   end

   // TX FIFO pointers and occupancy
   always_ff @(posedge CLK) begin
      if (!RST_) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_level  <= '0;
      end else begin
         if (tx_push_ok) begin
            tx_wr_ptr <= tx_wr_ptr + 1'b1;
         end
         if (tx_pop) begin
            tx_rd_ptr <= tx_rd_ptr + 1'b1;
         end
         case ({tx_push_ok, tx_pop})
            2'b10:   tx_level <= tx_level + 1'b1;
            2'b01:   tx_level <= tx_level - 1'b1;
            default: tx_level <= tx_level;
         endcase
      end
   end

   // RX FIFO data array
   always_ff @(posedge CLK) begin
      if (rx_wr) begin
         rx_mem[rx_wr_ptr] <= M_RX_DATA;
      end
   end

   // RX FIFO pointers and occupancy
   always_ff @(posedge CLK) begin
      if (!RST_) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_level  <= '0;
      end else begin
         if (rx_wr) begin
            rx_wr_ptr <= rx_wr_ptr + 1'b1;
         end
         if (rx_rd) begin
            rx_rd_ptr <= rx_rd_ptr + 1'b1;
         end
         case ({rx_wr, rx_rd})
            2'b10:   rx_level <= rx_level + 1'b1;
            2'b01:   rx_level <= rx_level - 1'b1;
            default: rx_level <= rx_level;
         endcase
      end
   end

   // Frame sequencer; the timeout and gap timers are down-counters that
   // finish on reaching zero.
   always_ff @(posedge CLK) begin
      if (!RST_) begin
         state     <= ST_IDLE;
         m_tx_en   <= 1'b0;
         m_tx_data <= '0;
         m_csi     <= '0;
         tmo_cnt   <= '0;
         gap_cnt   <= '0;
      end else begin
         m_tx_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_pop) begin
                  {m_csi, m_tx_data} <= tx_mem[tx_rd_ptr];
                  m_tx_en            <= 1'b1;
                  state              <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               tmo_cnt <= TMO_LOAD;
               state   <= ST_WAIT_TC;
            end
            ST_WAIT_TC: begin
               if (M_TC || tmo_expire) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky error flags; a new event beats a simultaneous clear
   always_ff @(posedge CLK) begin
      if (!RST_) begin
         err <= '0;
      end else begin
         err <= (CLR_ERR ? 3'b000 : err) | err_set;
      end
   end

   assign TX_FULL   = tx_full;
   assign TX_LEVEL  = tx_level;
   assign RX_EMPTY  = rx_empty;
   assign POP_DATA  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
   assign M_TX_EN   = m_tx_en;
   assign M_TX_DATA = m_tx_data;
   assign M_CSI     = m_csi;
   assign ACTIVE    = (state != ST_IDLE);
   assign ERR       = err;

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Testbench for spi_xfer_queue: vector table for FIFO fill/overflow/error
// clearing, directed frame sequences, and a randomized run against a
// transaction-level queue model.
module tb_spi_xfer_queue;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int GAP   = 2;
   localparam int TMO   = 255;

   logic          CLK = 1'b0;
   logic          RST_;
   logic          PUSH;
   logic [7:0]    PUSH_DATA;
   logic [1:0]    PUSH_CS;
   logic          TX_FULL;
   logic [AW:0]   TX_LEVEL;
   logic          POP;
   logic [7:0]    POP_DATA;
   logic          RX_EMPTY;
   logic          M_TX_EN;
   logic [7:0]    M_TX_DATA;
   logic [1:0]    M_CSI;
   logic          M_BUSY;
   logic          M_TC;
   logic [7:0]    M_RX_DATA;
   logic          ACTIVE;
   logic [2:0]    ERR;
   logic          CLR_ERR;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int last_tc  = -1000;

   always #5 CLK = ~CLK;

   spi_xfer_queue #(
      .DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(CLK), .RST_(RST_), .PUSH(PUSH), .PUSH_DATA(PUSH_DATA),
      .PUSH_CS(PUSH_CS), .TX_FULL(TX_FULL), .TX_LEVEL(TX_LEVEL), .POP(POP),
      .POP_DATA(POP_DATA), .RX_EMPTY(RX_EMPTY), .M_TX_EN(M_TX_EN),
      .M_TX_DATA(M_TX_DATA), .M_CSI(M_CSI), .M_BUSY(M_BUSY), .M_TC(M_TC),
      .M_RX_DATA(M_RX_DATA), .ACTIVE(ACTIVE), .ERR(ERR), .CLR_ERR(CLR_ERR)
   );

   typedef struct {
      logic       rst_;
      logic       push;
      logic [7:0] data;
      logic [1:0] cs;
      logic       busy;
      logic       clr;
      logic       exp_full;
      logic [3:0] exp_level;
      logic [2:0] exp_err;
      logic       exp_active;
   } vec_t;

   vec_t vt [15];

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle_inputs();
      PUSH      = 1'b0;
      PUSH_DATA = 8'h00;
      PUSH_CS   = 2'd0;
      POP       = 1'b0;
      M_BUSY    = 1'b0;
      M_TC      = 1'b0;
      M_RX_DATA = 8'h00;
      CLR_ERR   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST_ = 1'b0;
      tick();
      check("rst_tx_en",   M_TX_EN,   0);
      check("rst_tx_data", M_TX_DATA, 0);
      check("rst_csi",     M_CSI,     0);
      check("rst_err",     ERR,       0);
      check("rst_active",  ACTIVE,    0);
      check("rst_tx_full", TX_FULL,   0);
      check("rst_level",   TX_LEVEL,  0);
      check("rst_rx_empty", RX_EMPTY, 1);
      check("rst_pop_data", POP_DATA, 0);
      RST_ = 1'b1;
      last_tc = -1000;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic [1:0] cs);
      PUSH = 1'b1; PUSH_DATA = d; PUSH_CS = cs;
      tick();
      PUSH = 1'b0;
   endtask

   // Acts as spi_master for one frame: waits for the launch, checks it, then
   // answers with M_TC a few cycles later. exact_gap asks for the precise
   // back-to-back spacing (gap cycles, one IDLE cycle, then LAUNCH).
   task automatic serve_frame(input logic [7:0] d, input logic [1:0] cs,
                              input logic [7:0] rx, input logic exact_gap);
      int w = 0;
      while (!M_TX_EN && w < 64) begin
         tick();
         w++;
      end
      check("frame_launch", M_TX_EN, 1);
      check("frame_data", M_TX_DATA, d);
      check("frame_cs", M_CSI, cs);
      if (exact_gap) check("frame_gap_exact", cyc - last_tc, GAP + 2);
      else           check("frame_gap_min", (cyc - last_tc) >= (GAP + 1), 1);
      M_BUSY = 1'b1;
      tick();
      check("frame_single_pulse", M_TX_EN, 0);
      tick();
      tick();
      M_TC = 1'b1; M_RX_DATA = rx;
      tick();
      M_TC = 1'b0; M_BUSY = 1'b0;
      last_tc = cyc - 1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int pulses;

      RST_ = 1'b0;
      idle_inputs();

      // ---------------- vector table: TX fill, overflow, clear ----------
      vt[0] = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000, 1'b0};
      for (int i = 1; i <= 8; i++)
         vt[i] = '{1'b1, 1'b1, 8'(8'h10 + i), 2'(i % 4), 1'b1, 1'b0,
                   (i == 8), 4'(i), 3'b000, 1'b0};
      vt[9]  = '{1'b1, 1'b1, 8'h99, 2'd1, 1'b1, 1'b0, 1'b1, 4'd8, 3'b001, 1'b0};
      vt[10] = '{1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b1, 4'd8, 3'b001, 1'b0};
      vt[11] = '{1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1, 4'd8, 3'b000, 1'b0};
      vt[12] = '{1'b1, 1'b1, 8'h77, 2'd2, 1'b1, 1'b1, 1'b1, 4'd8, 3'b001, 1'b0};
      vt[13] = '{1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b1, 4'd8, 3'b000, 1'b0};
      vt[14] = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000, 1'b0};

      for (int i = 0; i < 15; i++) begin
         RST_ = vt[i].rst_; PUSH = vt[i].push; PUSH_DATA = vt[i].data;
         PUSH_CS = vt[i].cs; M_BUSY = vt[i].busy; CLR_ERR = vt[i].clr;
         tick();
         check($sformatf("vec%0d_full", i),   TX_FULL,  vt[i].exp_full);
         check($sformatf("vec%0d_level", i),  TX_LEVEL, vt[i].exp_level);
         check($sformatf("vec%0d_err", i),    ERR,      vt[i].exp_err);
         check($sformatf("vec%0d_active", i), ACTIVE,   vt[i].exp_active);
      end

      // ---------------- single byte, cycle-exact latency ---------------
      do_reset();
      repeat (3) tick();
      push_byte(8'hA5, 2'd2);
      check("single_n1_no_pulse", M_TX_EN, 0);
      tick();
      check("single_n2_pulse", M_TX_EN, 1);
      check("single_data", M_TX_DATA, 8'hA5);
      check("single_cs", M_CSI, 2);
      check("single_active", ACTIVE, 1);
      M_BUSY = 1'b1;
      pulses = 0;
      for (int i = 0; i < 27; i++) begin
         tick();
         if (M_TX_EN) pulses++;
      end
      check("single_extra_pulses", pulses, 0);
      check("single_rx_empty_pre", RX_EMPTY, 1);
      M_TC = 1'b1; M_RX_DATA = 8'h3C;
      tick();
      M_TC = 1'b0; M_BUSY = 1'b0;
      check("single_rx_empty_post", RX_EMPTY, 0);
      check("single_pop_data", POP_DATA, 8'h3C);
      check("single_data_held", M_TX_DATA, 8'hA5);
      check("single_cs_held", M_CSI, 2);
      POP = 1'b1;
      tick();
      POP = 1'b0;
      check("single_drained", RX_EMPTY, 1);
      check("single_pop_zero", POP_DATA, 0);

      // ---------------- burst of 8 then RX overrun on 9th -------------
      do_reset();
      M_BUSY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         PUSH = 1'b1; PUSH_DATA = 8'(i + 1); PUSH_CS = 2'(i % 4);
         tick();
      end
      PUSH = 1'b0;
      check("burst_full", TX_FULL, 1);
      check("burst_level", TX_LEVEL, 8);
      M_BUSY = 1'b0;
      for (int i = 0; i < 8; i++)
         serve_frame(8'(i + 1), 2'(i % 4), 8'(8'hC0 + i), (i != 0));
      check("burst_no_err", ERR, 0);
      tick();
      push_byte(8'h09, 2'd1);
      serve_frame(8'h09, 2'd1, 8'hC8, 1'b0);
      check("overrun_err", ERR, 3'b010);
      for (int i = 0; i < 8; i++) begin
         check("overrun_not_empty", RX_EMPTY, 0);
         check("overrun_pop_data", POP_DATA, 8'(8'hC0 + i));
         POP = 1'b1;
         tick();
         POP = 1'b0;
      end
      check("overrun_drained", RX_EMPTY, 1);

      // ---------------- timeout then next byte launches ---------------
      do_reset();
      PUSH = 1'b1; PUSH_DATA = 8'h55; PUSH_CS = 2'd3;
      tick();
      PUSH_DATA = 8'h66; PUSH_CS = 2'd1;
      tick();
      PUSH = 1'b0;
      check("tmo_launch", M_TX_EN, 1);
      check("tmo_launch_data", M_TX_DATA, 8'h55);
      p = cyc;
      while (cyc < p + TMO) tick();
      check("tmo_not_yet", ERR, 0);
      check("tmo_still_waiting", ACTIVE, 1);
      tick();
      check("tmo_err", ERR, 3'b100);
      check("tmo_in_gap", ACTIVE, 1);
      check("tmo_no_rx", RX_EMPTY, 1);
      tick();
      tick();
      check("tmo_back_idle", ACTIVE, 0);
      tick();
      check("tmo_next_launch", M_TX_EN, 1);
      check("tmo_next_data", M_TX_DATA, 8'h66);
      check("tmo_next_cs", M_CSI, 1);
      tick();
      tick();
      M_TC = 1'b1; M_RX_DATA = 8'h77;
      tick();
      M_TC = 1'b0;
      check("tmo_next_rx", POP_DATA, 8'h77);
      check("tmo_err_sticky", ERR, 3'b100);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check("tmo_err_cleared", ERR, 0);

      // ---------------- reset in the middle of a frame ----------------
      do_reset();
      for (int i = 0; i < 4; i++) push_byte(8'(8'hD0 + i), 2'(i));
      check("midrst_level", TX_LEVEL, 3);
      check("midrst_active", ACTIVE, 1);
      repeat (3) tick();
      RST_ = 1'b0;
      tick();
      RST_ = 1'b1;
      check("midrst_level0", TX_LEVEL, 0);
      check("midrst_rx_empty", RX_EMPTY, 1);
      check("midrst_tx_en", M_TX_EN, 0);
      check("midrst_idle", ACTIVE, 0);
      M_TC = 1'b1; M_RX_DATA = 8'hEE;
      tick();
      M_TC = 1'b0;
      check("midrst_tc_ignored", RX_EMPTY, 1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (M_TX_EN) pulses++;
      end
      check("midrst_no_launch", pulses, 0);

      // ---------------- randomized run vs. queue model ----------------
      begin : rnd
         logic [9:0] txq [$];
         logic [7:0] rxq [$];
         logic [2:0] merr;
         logic [2:0] set;
         logic [7:0] cur_rx;
         logic       pend, tc, spur, pop, push, clr, full;
         int         tc_cnt;

         do_reset();
         merr = 3'b000;
         pend = 1'b0;
         tc_cnt = 0;
         cur_rx = 8'h00;
         for (int c = 0; c < 3000; c++) begin
            if (M_TX_EN) begin
               check("rnd_launch_expected", (!pend && txq.size() > 0), 1);
               if (txq.size() > 0) begin
                  check("rnd_launch_word", {M_CSI, M_TX_DATA}, txq[0]);
                  void'(txq.pop_front());
               end
               check("rnd_gap", (cyc - last_tc) >= (GAP + 1), 1);
               pend   = 1'b1;
               tc_cnt = $urandom_range(1, 10);
               cur_rx = 8'($urandom);
            end
            check("rnd_level", TX_LEVEL, txq.size());
            check("rnd_rx_empty", RX_EMPTY, (rxq.size() == 0));
            check("rnd_pop_data", POP_DATA, (rxq.size() > 0) ? rxq[0] : 8'h00);
            check("rnd_err", ERR, merr);

            tc = 1'b0;
            if (pend && tc_cnt == 0) begin
               tc = 1'b1;
               pend = 1'b0;
               last_tc = cyc;
            end else if (pend) begin
               tc_cnt--;
            end
            spur = !pend && !tc && (($urandom % 20) == 0);
            push = (c < 2700) && (txq.size() < DEPTH - 1) && (($urandom % 3) == 0);
            pop  = ($urandom % ((c < 1500) ? 16 : 3)) == 0;
            clr  = ($urandom % 64) == 0;

            PUSH      = push;
            PUSH_DATA = 8'($urandom);
            PUSH_CS   = 2'($urandom);
            POP       = pop;
            CLR_ERR   = clr;
            M_BUSY    = pend || (($urandom % 6) == 0);
            M_TC      = tc || spur;
            M_RX_DATA = tc ? cur_rx : 8'($urandom);

            full = (rxq.size() == DEPTH);
            set  = 3'b000;
            if (pop && rxq.size() > 0) void'(rxq.pop_front());
            if (tc) begin
               if (full && !pop) set[1] = 1'b1;
               else              rxq.push_back(cur_rx);
            end
            if (push) txq.push_back({PUSH_CS, PUSH_DATA});
            merr = (clr ? 3'b000 : merr) | set;
            tick();
         end
         idle_inputs();
         check("rnd_all_launched", txq.size(), 0);
         check("rnd_no_pending", pend, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_xfer_queue.md
Name: spi_xfer_queue

Overview:
- Transaction queue that sits directly upstream of spi_master.
- Buffers host bytes together with a chip-select code in a TX FIFO.
- Launches one spi_master frame per byte via a single-cycle Tx_En pulse.
- Captures each received byte on TC into an RX FIFO the host drains. Adds an inter-frame gap, a completion timeout, and sticky error flags.

Parameters:
- DEPTH, 8, entries per FIFO (power of 2, ≥2).
- AW, 3, log2(DEPTH).
- GAP_CYCLES, 2, minimum CLK cycles in GAP after each frame before the next launch (≥1).
- TIMEOUT_CYCLES, 255, max CLK cycles in WAIT_TC before abort (≥16; counter width 16).

Ports:
- CLK in 1: system clock, rising edge.
- RST_ in 1: synchronous active-low reset.
- PUSH in 1: write {PUSH_CS, PUSH_DATA} to TX FIFO.
- PUSH_DATA in 8: byte to transmit.
- PUSH_CS in 2: chip-select code for this byte.
- TX_FULL out 1: TX FIFO full.
- TX_LEVEL out AW+1: TX FIFO occupancy.
- POP in 1: consume RX FIFO head.
- POP_DATA out 8: RX FIFO head (first-word-fall-through).
- RX_EMPTY out 1: RX FIFO empty.
- M_TX_EN out 1: to spi_master Tx_En.
- M_TX_DATA out 8: to spi_master Tx_DATA.
- M_CSI out 2: to spi_master CSi.
- M_BUSY in 1: from spi_master BUSY.
- M_TC in 1: from spi_master TC (one-cycle pulse).
- M_RX_DATA in 8: from spi_master Rx_DATA.
- ACTIVE out 1: FSM not in IDLE.
- ERR out 3: sticky flags {TIMEOUT, RX_OVF, TX_OVF}.
- CLR_ERR in 1: clears ERR.

Behaviour:
- Reset: sampled on rising CLK while RST_=0.
  - Both FIFOs are emptied. FSM goes to IDLE.
  - Outputs: M_TX_EN=0, M_TX_DATA=0, M_CSI=0, ERR=0, ACTIVE=0, TX_FULL=0, TX_LEVEL=0, RX_EMPTY=1, POP_DATA=0.
  - Reset mid-frame abandons the frame with no RX write.
- TX FIFO: 10-bit entries {cs,data}.
  - PUSH while TX_FULL: write ignored, ERR[0] set.
  - PUSH and an internal pop in the same cycle both take effect; level is unchanged, including at full.
- RX FIFO: 8-bit entries.
  - POP while RX_EMPTY: ignored, no error.
  - Write and POP in the same cycle both take effect.
- Pointers wrap modulo DEPTH. Full/empty are derived from the AW+1-bit level.
- FSM states: IDLE, LAUNCH, WAIT_TC, GAP.
  - IDLE: if TX not empty and M_BUSY=0, pop the head into M_TX_DATA/M_CSI and go to LAUNCH.
  - LAUNCH: M_TX_EN=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_TC.
  - WAIT_TC:
    - M_TC=1: write M_RX_DATA to the RX FIFO. If RX is full and there is no same-cycle POP, drop the byte and set ERR[1]. Go to GAP.
    - Else if the timeout counter reaches TIMEOUT_CYCLES−1: set ERR[2], no RX write, go to GAP.
    - Otherwise increment the counter.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- M_TX_EN is registered.
  - With an empty queue and FSM in IDLE, PUSH in cycle n gives M_TX_EN high in cycle n+2.
  - Back-to-back frames are separated by ≥ GAP_CYCLES+1 cycles after the M_TC cycle.
- M_CSI and M_TX_DATA are held from LAUNCH until the next pop; they hold their last value in IDLE.
- ACTIVE=1 in LAUNCH, WAIT_TC and GAP.
- CLR_ERR clears ERR. A set event in the same cycle wins, so that flag stays 1.
- M_TC outside WAIT_TC is ignored.

Test Plan:
- Single byte: PUSH 0xA5 cs=2 at cycle 10; the model returns M_TC with M_RX_DATA=0x3C at cycle 40 → M_TX_EN high only at cycle 12 with M_TX_DATA=0xA5, M_CSI=2. RX_EMPTY falls at cycle 41 with POP_DATA=0x3C.
- Burst: push 0x01..0x08 back-to-back (cs=0..3 cycling) → TX_FULL after the 8th. Exactly 8 M_TX_EN pulses in order, each ≥3 cycles after the previous M_TC. The RX FIFO holds the 8 echoed bytes in order.
- Overflow: with FSM stalled (M_BUSY=1) push 9 bytes → 9th ignored, ERR=3'b001, TX_LEVEL=8. CLR_ERR → ERR=0.
- RX overrun: 9 frames with no POP → 9th M_RX_DATA dropped, ERR[1]=1. The first 8 bytes are intact on pop.
- Timeout: push 0x55 and the model never asserts M_TC → after 255 cycles in WAIT_TC, ERR[2]=1, no RX write, FSM returns to IDLE after the gap. The next queued byte launches normally.
- Reset mid-frame: RST_=0 for 1 cycle during WAIT_TC with 3 bytes queued → TX_LEVEL=0, RX_EMPTY=1, M_TX_EN=0. A subsequent M_TC is ignored.
